// File: rtl/core2wb.sv
// Core request/response bus to Wishbone pipelined master bridge with outstanding-transaction limit.
// Optional response watchdog and abort path enabled by defining CORE2WB_TIMEOUT_EN.
module core2wb #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  output logic        core_gnt,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_m,
  input  logic [31:0] wb_dat_s,
  input  logic        wb_stall,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;

  if (MAX_OUT < 1 || MAX_OUT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("core2wb: MAX_OUT must be 1..15 and TIMEOUT at least 1");
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stb_q, stb_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     adr_q, dat_m_q, rdata_q;
  logic            resp;
  logic            in_abort;

  assign wb_cyc = (state_q == ACTIVE);
  // Acks or errors outside a bus cycle are not responses.
  assign resp   = wb_cyc && (wb_ack || wb_err);

`ifdef CORE2WB_TIMEOUT_EN
  localparam logic [1:0] ABORT = 2'd2;
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout;

  assign in_abort = (state_q == ABORT);
  assign timeout  = wb_cyc && !resp && (wd_q == WdLast);

  always_comb begin
    wd_d = '0;
    if (wb_cyc && !resp) wd_d = wd_q + WdW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign in_abort = 1'b0;
`endif

  assign core_gnt = rst_n && core_req && (!stb_q || !wb_stall) && (cnt_q < MaxCnt) && !in_abort;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stb_d    = stb_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;

    if (core_gnt && !resp)      cnt_d = cnt_q + OneCnt;
    else if (!core_gnt && resp) cnt_d = cnt_q - OneCnt;

    // A grant in the accepting cycle keeps stb high for a back-to-back request.
    if (core_gnt)                stb_d = 1'b1;
    else if (stb_q && !wb_stall) stb_d = 1'b0;

    if (resp) begin
      rvalid_d = 1'b1;
      err_d    = wb_err;
    end

    case (state_q)
      IDLE: begin
        if (core_gnt) state_d = ACTIVE;
      end
      ACTIVE: begin
`ifdef CORE2WB_TIMEOUT_EN
        if (timeout) begin
          state_d = ABORT;
          stb_d   = 1'b0;
        end else
`endif
        if (resp && !core_gnt && cnt_q == OneCnt) state_d = IDLE;
      end
`ifdef CORE2WB_TIMEOUT_EN
      ABORT: begin
        // Fail one outstanding transaction per cycle until none remain.
        rvalid_d = 1'b1;
        err_d    = 1'b1;
        cnt_d    = cnt_q - OneCnt;
        if (cnt_q <= OneCnt) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stb_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_m_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      if (core_gnt) begin
        we_q    <= core_we;
        sel_q   <= core_be;
        adr_q   <= core_addr;
        dat_m_q <= core_wdata;
      end
      if (resp) rdata_q <= wb_dat_s;
    end
  end

  assign wb_stb      = stb_q;
  assign wb_we       = we_q;
  assign wb_sel      = sel_q;
  assign wb_adr      = adr_q;
  assign wb_dat_m    = dat_m_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign core_err    = err_q;

endmodule

// File: tb/tb_core2wb.sv
// Directed self-checking bench for core2wb (MAX_OUT=4, TIMEOUT=8).
// The abort scenario runs only when CORE2WB_TIMEOUT_EN is defined.
module tb_core2wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_gnt, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_m, wb_dat_s;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_ack, wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core2wb #(
    .MAX_OUT(4),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_dat_m   (wb_dat_m),
    .wb_dat_s   (wb_dat_s),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic stall,
                      input logic ack, input logic err, input logic [31:0] dat);
    @(negedge clk);
    core_req   = req;
    core_we    = we;
    core_be    = be;
    core_addr  = addr;
    core_wdata = wdata;
    wb_stall   = stall;
    wb_ack     = ack;
    wb_err     = err;
    wb_dat_s   = dat;
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 1'b0, 4'hF, addr, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rsp(input logic ack, input logic err, input logic [31:0] dat);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, ack, err, dat);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Request outputs must not move across an edge where stb and stall were both high.
  bit          hold_prev = 1'b0;
  logic [31:0] adr_prev, dat_prev;
  logic [5:0]  ctl_prev;
  always @(negedge clk) begin
    #2;
    if (hold_prev) begin
      check("stall_adr", wb_adr, adr_prev);
      check("stall_dat", wb_dat_m, dat_prev);
      check("stall_ctl", {26'h0, wb_cyc, wb_stb, wb_we, wb_sel[2:0]}, {26'h0, ctl_prev});
    end
    hold_prev = rst_n && wb_stb && wb_stall;
    adr_prev  = wb_adr;
    dat_prev  = wb_dat_m;
    ctl_prev  = {wb_cyc, wb_stb, wb_we, wb_sel[2:0]};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int act;
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_be = 4'h0; core_addr = '0; core_wdata = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_s = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt", {31'h0, core_gnt}, 32'h0);
    check("rst_cyc", {31'h0, wb_cyc}, 32'h0);
    check("rst_stb", {31'h0, wb_stb}, 32'h0);
    check("rst_rvalid", {31'h0, core_rvalid}, 32'h0);
    check("rst_err", {31'h0, core_err}, 32'h0);
    check("rst_adr", wb_adr, 32'h0);
    check("rst_dat_m", wb_dat_m, 32'h0);
    check("rst_sel_we", {27'h0, wb_sel, wb_we}, 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    rst_n = 1'b1;
    core_req = 1'b0;

    // Single read, ack two cycles after acceptance
    rd(32'h100);
    check("rd_gnt", {31'h0, core_gnt}, 32'h1);
    check("rd_cyc0", {31'h0, wb_cyc}, 32'h0);
    idle();
    check("rd_stb", {31'h0, wb_stb}, 32'h1);
    check("rd_adr", wb_adr, 32'h100);
    check("rd_we_sel", {27'h0, wb_sel, wb_we}, {27'h0, 4'hF, 1'b0});
    check("rd_cyc1", {31'h0, wb_cyc}, 32'h1);
    idle();
    check("rd_stb_clr", {31'h0, wb_stb}, 32'h0);
    check("rd_cyc2", {31'h0, wb_cyc}, 32'h1);
    rsp(1'b1, 1'b0, 32'hCAFE_F00D);
    check("rd_rvalid_early", {31'h0, core_rvalid}, 32'h0);
    idle();
    check("rd_rvalid", {31'h0, core_rvalid}, 32'h1);
    check("rd_rdata", core_rdata, 32'hCAFE_F00D);
    check("rd_err", {31'h0, core_err}, 32'h0);
    check("rd_cyc_end", {31'h0, wb_cyc}, 32'h0);
    idle();
    check("rd_rvalid_once", {31'h0, core_rvalid}, 32'h0);

    // Write held by three stall cycles; a second request must wait
    step(1'b1, 1'b1, 4'h3, 32'h20, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wr_gnt", {31'h0, core_gnt}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'hF, 32'h24, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("wr_stall_gnt", {31'h0, core_gnt}, 32'h0);
      check("wr_stall_stb", {31'h0, wb_stb}, 32'h1);
      check("wr_stall_adr", wb_adr, 32'h20);
      check("wr_stall_dat", wb_dat_m, 32'h1234);
      check("wr_stall_we_sel", {27'h0, wb_sel, wb_we}, {27'h0, 4'h3, 1'b1});
    end
    idle();
    check("wr_accept_stb", {31'h0, wb_stb}, 32'h1);
    check("wr_accept_adr", wb_adr, 32'h20);
    rsp(1'b1, 1'b0, 32'h0);
    check("wr_stb_clr", {31'h0, wb_stb}, 32'h0);
    idle();
    check("wr_rvalid", {31'h0, core_rvalid}, 32'h1);
    check("wr_cyc_end", {31'h0, wb_cyc}, 32'h0);

    // Five back-to-back reads against a limit of four
    for (int i = 0; i < 4; i++) begin
      rd(32'h1000 + 32'(i) * 4);
      check("full_gnt", {31'h0, core_gnt}, 32'h1);
    end
    rd(32'h1010);
    check("full_block0", {31'h0, core_gnt}, 32'h0);
    check("full_last_stb", {31'h0, wb_stb}, 32'h1);
    check("full_last_adr", wb_adr, 32'h100C);
    rd(32'h1010);
    check("full_block1", {31'h0, core_gnt}, 32'h0);
    step(1'b1, 1'b0, 4'hF, 32'h1010, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA0);
    check("full_block_on_ack", {31'h0, core_gnt}, 32'h0);
    rd(32'h1010);
    check("full_gnt_after_ack", {31'h0, core_gnt}, 32'h1);
    check("full_rvalid0", {31'h0, core_rvalid}, 32'h1);
    check("full_rdata0", core_rdata, 32'hA0);
    for (int j = 0; j < 4; j++) begin
      rsp(1'b1, 1'b0, 32'hB0 + 32'(j));
      if (j == 0) begin
        check("full_fifth_stb", {31'h0, wb_stb}, 32'h1);
        check("full_fifth_adr", wb_adr, 32'h1010);
      end else begin
        check("full_drain_rvalid", {31'h0, core_rvalid}, 32'h1);
        check("full_drain_rdata", core_rdata, 32'hB0 + 32'(j) - 1);
      end
    end
    idle();
    check("full_last_rvalid", {31'h0, core_rvalid}, 32'h1);
    check("full_last_rdata", core_rdata, 32'hB3);
    check("full_cyc_end", {31'h0, wb_cyc}, 32'h0);

    // Three reads, middle one answered with ack and err together
    for (int i = 0; i < 3; i++) begin
      rd(32'h200 + 32'(i) * 4);
      check("err_gnt", {31'h0, core_gnt}, 32'h1);
    end
    idle();
    rsp(1'b1, 1'b0, 32'h11);
    rsp(1'b1, 1'b1, 32'h22);
    check("err_rv0", {30'h0, core_rvalid, core_err}, {30'h0, 2'b10});
    check("err_rdata0", core_rdata, 32'h11);
    rsp(1'b1, 1'b0, 32'h33);
    check("err_rv1", {30'h0, core_rvalid, core_err}, {30'h0, 2'b11});
    check("err_cyc_mid", {31'h0, wb_cyc}, 32'h1);
    idle();
    check("err_rv2", {30'h0, core_rvalid, core_err}, {30'h0, 2'b10});
    check("err_rdata2", core_rdata, 32'h33);
    check("err_cyc_end", {31'h0, wb_cyc}, 32'h0);
    rsp(1'b1, 1'b0, 32'h44);
    check("stray_ack_rv0", {31'h0, core_rvalid}, 32'h0);
    idle();
    check("stray_ack_rv1", {31'h0, core_rvalid}, 32'h0);

    // Reset with two reads outstanding, then a late ack
    rd(32'h300);
    check("rstmid_gnt0", {31'h0, core_gnt}, 32'h1);
    rd(32'h304);
    check("rstmid_gnt1", {31'h0, core_gnt}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    core_req = 1'b1;
    #1;
    check("rstmid_gnt_low", {31'h0, core_gnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    core_req = 1'b0;
    wb_ack = 1'b1;
    #1;
    check("rstmid_cyc", {31'h0, wb_cyc}, 32'h0);
    check("rstmid_stb", {31'h0, wb_stb}, 32'h0);
    idle();
    check("rstmid_late_ack", {31'h0, core_rvalid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(32'h400 + 32'(i) * 4);
      check("rstmid_cnt_gnt", {31'h0, core_gnt}, 32'h1);
    end
    rd(32'h410);
    check("rstmid_cnt_full", {31'h0, core_gnt}, 32'h0);
    for (int j = 0; j < 4; j++) rsp(1'b1, 1'b0, 32'h0);
    idle();
    check("rstmid_drain_cyc", {31'h0, wb_cyc}, 32'h0);

`ifdef CORE2WB_TIMEOUT_EN
    // Two reads never answered: abort after eight waiting cycles
    rd(32'h500);
    check("to_gnt0", {31'h0, core_gnt}, 32'h1);
    rd(32'h504);
    check("to_gnt1", {31'h0, core_gnt}, 32'h1);
    act = wb_cyc ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (!wb_cyc) break;
      act++;
    end
    check("to_active_cycles", 32'(act), 32'd8);
    core_req = 1'b1;
    #1;
    check("to_abort_gnt", {31'h0, core_gnt}, 32'h0);
    check("to_abort_stb", {31'h0, wb_stb}, 32'h0);
    check("to_abort_rv_pre", {31'h0, core_rvalid}, 32'h0);
    idle();
    check("to_rv0", {30'h0, core_rvalid, core_err}, {30'h0, 2'b11});
    idle();
    check("to_rv1", {30'h0, core_rvalid, core_err}, {30'h0, 2'b11});
    check("to_cyc", {31'h0, wb_cyc}, 32'h0);
    idle();
    check("to_rv_end", {31'h0, core_rvalid}, 32'h0);
    rd(32'h600);
    check("to_idle_gnt", {31'h0, core_gnt}, 32'h1);
    idle();
    rsp(1'b1, 1'b0, 32'h0);
    idle();
    check("to_final_rv", {31'h0, core_rvalid}, 32'h1);
`else
    act = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
